// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
// Holds the ALU function-select encoding, the RV32I opcode and funct3/funct7
// constants decoded by this stage, and the datapath width.
package alu_pkg;

    // Datapath width. Only 32 is supported.
    localparam int unsigned XLEN = 32;

    // ALU function select driven to the execute stage.
    typedef enum logic [3:0] {
        AluAdd   = 4'b0000,
        AluSub   = 4'b0001,
        AluXor   = 4'b0010,
        AluOr    = 4'b0011,
        AluAnd   = 4'b0100,
        AluSlt   = 4'b0101,
        AluSltu  = 4'b0110,
        AluSll   = 4'b0111,
        AluSrl   = 4'b1000,
        AluSra   = 4'b1001,
        AluPassA = 4'b1111
    } alu_sel_e;

    // Major opcodes handled by this stage.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 values shared by OP and OP-IMM.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 values: base encoding and the SUB/SRA alternate.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder for the ALU issue stage.
// Ports:
//   instr    - instruction word
//   sel      - ALU function select
//   use_imm  - operand B comes from the I-type immediate
//   imm      - sign-extended I-type immediate, or the LUI upper immediate
//   use_lui  - LUI: operand A is imm, operand B is zero
//   illegal  - instruction is not an R-type, I-type ALU or LUI
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]     instr,
    output alu_sel_e        sel,
    output logic            use_imm,
    output logic [XLEN-1:0] imm,
    output logic            use_lui,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Function select shared by OP and OP-IMM when funct7 is the base encoding.
    alu_sel_e base_sel;

    always_comb begin
        base_sel = AluAdd;
        unique case (funct3)
            F3_ADD_SUB: base_sel = AluAdd;
            F3_SLL:     base_sel = AluSll;
            F3_SLT:     base_sel = AluSlt;
            F3_SLTU:    base_sel = AluSltu;
            F3_XOR:     base_sel = AluXor;
            F3_SRL_SRA: base_sel = AluSrl;
            F3_OR:      base_sel = AluOr;
            F3_AND:     base_sel = AluAnd;
            default:    base_sel = AluAdd;
        endcase
    end

    always_comb begin
        sel     = AluAdd;
        use_imm = 1'b0;
        use_lui = 1'b0;
        illegal = 1'b0;
        imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};

        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    sel = base_sel;
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    sel = AluSub;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    sel = AluSra;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                // For shifts the upper immediate bits act as funct7.
                if (funct3 == F3_SLL) begin
                    sel     = AluSll;
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == F3_SRL_SRA) begin
                    if (funct7 == F7_BASE) begin
                        sel = AluSrl;
                    end else if (funct7 == F7_ALT) begin
                        sel = AluSra;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    sel = base_sel;
                end
            end
            OPC_LUI: begin
                use_lui = 1'b1;
                sel     = AluPassA;
                imm     = {instr[31:12], 12'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the ALU.
// Accepts one instruction per valid/ready handshake with its register-file
// read data, applies write-back forwarding and registers the ALU operands,
// function select and destination into a one-deep pipeline register.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - upstream handshake
//   instr                 - RV32I instruction word
//   rs1_data, rs2_data    - register-file read data for instr[19:15]/[24:20]
//   wb_en, wb_rd, wb_data - same-cycle write-back for forwarding
//   flush                 - drop the held and any incoming instruction
//   out_valid / out_ready - downstream handshake
//   opA, opB, aluOutSel   - registered ALU operands and function select
//   rd                    - destination register (0 = no write)
//   illegal               - issued instruction is not supported here
module alu_issue_stage #(
    parameter int unsigned XLEN       = 32,  // only 32 is supported
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       opA,
    output logic [XLEN-1:0]       opB,
    output logic [3:0]            aluOutSel,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  illegal
);
    import alu_pkg::*;

    // Decode
    alu_sel_e        dec_sel;
    logic            dec_use_imm;
    logic            dec_use_lui;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    alu_decode u_decode (
        .instr   (instr),
        .sel     (dec_sel),
        .use_imm (dec_use_imm),
        .imm     (dec_imm),
        .use_lui (dec_use_lui),
        .illegal (dec_illegal)
    );

    // Operand resolution: x0 reads zero, otherwise a same-cycle write-back wins
    // over the (stale) register-file data.
    logic [REG_ADDR_W-1:0] rs1_idx;
    logic [REG_ADDR_W-1:0] rs2_idx;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;

    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];

    always_comb begin
        rs1_val = rs1_data;
        if (rs1_idx == '0) begin
            rs1_val = '0;
        end else if (wb_en && wb_rd == rs1_idx) begin
            rs1_val = wb_data;
        end
    end

    always_comb begin
        rs2_val = rs2_data;
        if (rs2_idx == '0) begin
            rs2_val = '0;
        end else if (wb_en && wb_rd == rs2_idx) begin
            rs2_val = wb_data;
        end
    end

    // Next-state operands
    logic                  is_shift;
    logic [XLEN-1:0]       opb_raw;
    logic [XLEN-1:0]       opa_d;
    logic [XLEN-1:0]       opb_d;
    logic [3:0]            sel_d;
    logic [REG_ADDR_W-1:0] rd_d;

    assign is_shift = (dec_sel == AluSll) || (dec_sel == AluSrl) || (dec_sel == AluSra);

    always_comb begin
        opa_d   = rs1_val;
        opb_raw = dec_use_imm ? dec_imm : rs2_val;
        sel_d   = dec_sel;
        rd_d    = instr[11:7];
        if (dec_use_lui) begin
            opa_d   = dec_imm;
            opb_raw = '0;
        end
        // Shift count is limited to 0..31 downstream.
        opb_d = is_shift ? {{(XLEN-5){1'b0}}, opb_raw[4:0]} : opb_raw;
        if (dec_illegal) begin
            opa_d = '0;
            opb_d = '0;
            sel_d = AluAdd;
            rd_d  = '0;
        end
    end

    // Handshake and pipeline register
    logic                  out_valid_q;
    logic [XLEN-1:0]       opa_q;
    logic [XLEN-1:0]       opb_q;
    logic [3:0]            sel_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  illegal_q;
    logic                  accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            sel_q       <= 4'b0000;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
            illegal_q   <= dec_illegal;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign opA       = opa_q;
    assign opB       = opb_q;
    assign aluOutSel = sel_q;
    assign rd        = rd_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed literal cases followed by
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [3:0]  aluOutSel;
    logic [4:0]  rd;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    alu_issue_stage #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opA       (opA),
        .opB       (opB),
        .aluOutSel (aluOutSel),
        .rd        (rd),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] read_reg(input logic [4:0] idx, input logic [31:0] d,
                                             input logic we, input logic [4:0] wr,
                                             input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (we && wr == idx) return wd;
        return d;
    endfunction

    function automatic void ref_issue(input logic [31:0] ins, input logic [31:0] r1d,
                                      input logic [31:0] r2d, input logic we,
                                      input logic [4:0] wr, input logic [31:0] wd,
                                      output logic [31:0] a, output logic [31:0] b,
                                      output logic [3:0] s, output logic [4:0] d,
                                      output logic ill);
        // funct3 -> select for the base funct7 encoding
        logic [3:0] tab [8];
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] v1;
        logic [31:0] v2;
        tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd2, 4'd8, 4'd3, 4'd4};
        f3 = ins[14:12];
        f7 = ins[31:25];
        v1 = read_reg(ins[19:15], r1d, we, wr, wd);
        v2 = read_reg(ins[24:20], r2d, we, wr, wd);
        ill = 1'b1;
        a = 32'h0;
        b = 32'h0;
        s = 4'd0;
        if (ins[6:0] == 7'h33) begin
            a = v1;
            b = v2;
            if (f7 == 7'h00) begin
                ill = 1'b0;
                s = tab[f3];
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                ill = 1'b0;
                s = (f3 == 3'd0) ? 4'd1 : 4'd9;
            end
        end else if (ins[6:0] == 7'h13) begin
            a = v1;
            b = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1) begin
                ill = (f7 != 7'h00);
                s = 4'd7;
            end else if (f3 == 3'd5) begin
                ill = !(f7 == 7'h00 || f7 == 7'h20);
                s = (f7 == 7'h20) ? 4'd9 : 4'd8;
            end else begin
                ill = 1'b0;
                s = tab[f3];
            end
        end else if (ins[6:0] == 7'h37) begin
            ill = 1'b0;
            a = {ins[31:12], 12'h000};
            b = 32'h0;
            s = 4'hF;
        end
        if (s == 4'd7 || s == 4'd8 || s == 4'd9) b = b % 32;
        d = ins[11:7];
        if (ill) begin
            a = 32'h0;
            b = 32'h0;
            s = 4'd0;
            d = 5'd0;
        end
    endfunction

    logic [31:0] nx_a, nx_b;
    logic [3:0]  nx_s;
    logic [4:0]  nx_d;
    logic        nx_ill;

    always_comb begin
        nx_a = 32'h0;
        nx_b = 32'h0;
        nx_s = 4'd0;
        nx_d = 5'd0;
        nx_ill = 1'b0;
        ref_issue(instr, rs1_data, rs2_data, wb_en, wb_rd, wb_data,
                  nx_a, nx_b, nx_s, nx_d, nx_ill);
    end

    logic        m_valid = 1'b0;
    logic [31:0] m_a = 32'h0, m_b = 32'h0;
    logic [3:0]  m_s = 4'd0;
    logic [4:0]  m_d = 5'd0;
    logic        m_ill = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_a <= 32'h0;
            m_b <= 32'h0;
            m_s <= 4'd0;
            m_d <= 5'd0;
            m_ill <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_a <= nx_a;
            m_b <= nx_b;
            m_s <= nx_s;
            m_d <= nx_d;
            m_ill <= nx_ill;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {31'h0, in_ready}, {31'h0, (!m_valid || out_ready)});
            chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
            if (m_valid) begin
                chk("opA", opA, m_a);
                chk("opB", opB, m_b);
                chk("aluOutSel", {28'h0, aluOutSel}, {28'h0, m_s});
                chk("rd", {27'h0, rd}, {27'h0, m_d});
                chk("illegal", {31'h0, illegal}, {31'h0, m_ill});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        int          pick;
        int          k;
        r = $urandom;
        pick = $urandom_range(0, 9);
        k = $urandom_range(0, 3);
        f7 = (k < 2) ? 7'h00 : (k == 2) ? 7'h20 : r[31:25];
        if (pick <= 3)      r[6:0] = 7'h33;
        else if (pick <= 6) r[6:0] = 7'h13;
        else if (pick == 7) r[6:0] = 7'h37;
        if (pick <= 6) begin
            r[31:25] = f7;
            r[19:15] = 5'($urandom_range(0, 3));
            r[24:20] = 5'($urandom_range(0, 3));
        end
        return r;
    endfunction

    initial begin
        repeat (3) tick();
        chk("rst out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst opA", opA, 32'h0);
        chk("rst opB", opB, 32'h0);
        chk("rst aluOutSel", {28'h0, aluOutSel}, 32'h0);
        chk("rst rd", {27'h0, rd}, 32'h0);
        chk("rst illegal", {31'h0, illegal}, 32'h0);
        rst_n = 1'b1;
        tick();

        // SUB x1,x1,x2
        out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h402080B3; rs1_data = 32'd10; rs2_data = 32'd3;
        tick();
        in_valid = 1'b0;
        chk("sub out_valid", {31'h0, out_valid}, 32'h1);
        chk("sub opA", opA, 32'd10);
        chk("sub opB", opB, 32'd3);
        chk("sub sel", {28'h0, aluOutSel}, 32'h1);
        chk("sub rd", {27'h0, rd}, 32'h1);

        // SRAI x2,x1,31
        in_valid = 1'b1; instr = 32'h41F0D113; rs1_data = 32'h80000000;
        tick();
        in_valid = 1'b0;
        chk("srai opA", opA, 32'h80000000);
        chk("srai opB", opB, 32'd31);
        chk("srai sel", {28'h0, aluOutSel}, 32'h9);

        // SLL x3,x1,x2 with an oversized shift amount
        in_valid = 1'b1; instr = 32'h002091B3; rs2_data = 32'h25;
        tick();
        in_valid = 1'b0;
        chk("sll opB", opB, 32'd5);
        chk("sll sel", {28'h0, aluOutSel}, 32'h7);

        // ADD x3,x1,x2 with write-back forwarding to x1
        in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'h11;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
        tick();
        in_valid = 1'b0;
        chk("fwd opA", opA, 32'hAA);

        // ADD x3,x0,x2 with write-back to x0
        in_valid = 1'b1; instr = 32'h002001B3; wb_rd = 5'd0;
        tick();
        in_valid = 1'b0; wb_en = 1'b0;
        chk("x0 opA", opA, 32'h0);

        // LUI x5,0x12345
        in_valid = 1'b1; instr = 32'h123452B7;
        tick();
        in_valid = 1'b0;
        chk("lui opA", opA, 32'h12345000);
        chk("lui opB", opB, 32'h0);
        chk("lui sel", {28'h0, aluOutSel}, 32'hF);
        chk("lui rd", {27'h0, rd}, 32'h5);

        // Load opcode is not handled here
        in_valid = 1'b1; instr = 32'h0000A103;
        tick();
        in_valid = 1'b0;
        chk("ill out_valid", {31'h0, out_valid}, 32'h1);
        chk("ill illegal", {31'h0, illegal}, 32'h1);
        chk("ill rd", {27'h0, rd}, 32'h0);
        chk("ill opA", opA, 32'h0);

        // Backpressure: hold ADD (opA=1) while SUB waits
        in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'd1; rs2_data = 32'd2;
        tick();
        instr = 32'h402080B3; rs1_data = 32'd7; rs2_data = 32'd4; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp opA", opA, 32'd1);
            chk("bp sel", {28'h0, aluOutSel}, 32'h0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp drain opA", opA, 32'd7);
        chk("bp drain opB", opB, 32'd4);
        chk("bp drain sel", {28'h0, aluOutSel}, 32'h1);
        chk("bp drain valid", {31'h0, out_valid}, 32'h1);

        // Flush wins over a same-cycle accept
        in_valid = 1'b1; flush = 1'b1; instr = 32'h002081B3;
        #1;
        chk("flush in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush out_valid", {31'h0, out_valid}, 32'h0);

        // Asynchronous reset while stalled
        in_valid = 1'b1; instr = 32'h123452B7;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("stall valid", {31'h0, out_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", {31'h0, out_valid}, 32'h0);
        chk("async rst opA", opA, 32'h0);
        chk("async rst sel", {28'h0, aluOutSel}, 32'h0);
        chk("async rst rd", {27'h0, rd}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic, checked by the per-cycle compare
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            instr     = rand_instr();
            rs1_data  = $urandom;
            rs2_data  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63));
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage sitting directly upstream of the ALU. Accepts one RV32I instruction per handshake together with register-file read data, and decodes R-type, I-type ALU and LUI. Applies write-back forwarding and registers opA, opB and aluOutSel plus the destination register toward the execute stage. Uses a one-deep valid/ready pipeline register with flush.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
REG_ADDR_W, 5, register index width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction and operands valid
in_ready  out  1  stage can accept this cycle
instr  in  32  RV32I instruction word
rs1_data  in  XLEN  register-file read port 1, indexed by instr[19:15]
rs2_data  in  XLEN  register-file read port 2, indexed by instr[24:20]
wb_en  in  1  write-back occurring this cycle
wb_rd  in  REG_ADDR_W  write-back destination
wb_data  in  XLEN  write-back value
flush  in  1  kill held and incoming instruction
out_valid  out  1  issued operation valid
out_ready  in  1  execute stage accepts
opA  out  XLEN  ALU operand A
opB  out  XLEN  ALU operand B
aluOutSel  out  4  ALU function select
rd  out  REG_ADDR_W  destination register; 0 means no write
illegal  out  1  instruction not supported by this stage

Behaviour:
- Reset (async, rst_n low): out_valid=0, opA=0, opB=0, aluOutSel=4'b0000, rd=0, illegal=0. Release takes effect synchronously at the next clk edge.
- Handshake: in_ready = !out_valid || out_ready, combinational, no dependence on in_valid.
- Accept when in_valid && in_ready. The output registers load on that edge, giving 1-cycle latency.
- Output stability: when out_valid && !out_ready, all outputs hold stable.
- Output draining: when out_ready && !accept, out_valid clears.
- Full throughput: back-to-back accept with out_ready held high issues one instruction per cycle.
- Flush: out_valid clears on the next edge and any same-cycle accept is discarded; flush has priority. in_ready is unaffected.
- aluOutSel encoding:
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 OR, 0100 AND
  - 0101 SLT (signed), 0110 SLTU
  - 0111 SLL, 1000 SRL, 1001 SRA
  - 1111 pass opA
- Decode, opcode 0110011 (OP): function from funct3/funct7.
  - funct7=0100000 is valid only with funct3 000 (SUB) or 101 (SRA).
  - Any other funct7 value other than 0000000 is illegal.
  - opA = rs1 value, opB = rs2 value.
- Decode, opcode 0010011 (OP-IMM): opB is the sign-extended instr[31:20].
  - SLLI requires instr[31:25]=0000000.
  - SRLI/SRAI require instr[31:25]=0000000 or 0100000 respectively; anything else is illegal.
- Decode, opcode 0110111 (LUI): opA = {instr[31:12],12'b0}, opB = 0, aluOutSel = 1111.
- Shift masking: for every shift (register or immediate) opB is masked to opB[4:0] zero-extended, so the downstream shift count is ≤31.
- Illegal handling: illegal=1, aluOutSel=0000, opA=opB=0, rd=0. Still issued with out_valid=1 so the trap logic can observe it.
- Operand resolution, for rs1 and rs2 independently:
  - index 0 gives 0 regardless of data and of wb.
  - else if wb_en && wb_rd==index, the value is wb_data.
  - else the value is rsX_data.
  - Forwarding is evaluated in the accept cycle only; values are captured, never re-read while stalled.
- rd: instr[11:7] for legal instructions.

Decomposition:
- Shared package alu_pkg:
  - alu_sel_e enum with the 4-bit codes above
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI
  - funct3 constants
  - XLEN
- Sub-module alu_decode: purely combinational; maps instr to {sel, use_imm, imm, use_lui, illegal}.
- The top level owns forwarding, handshake and the output registers.

Test Plan:
- Reset mid-stall: out_valid=1, out_ready=0, drop rst_n -> out_valid=0 and all outputs 0 immediately, without waiting for clk.
- Register-type SUB: instr=0x40208033 (sub x0? use rd=x1: 0x402080B3), rs1_data=10, rs2_data=3, out_ready=1 -> next cycle out_valid=1, opA=10, opB=3, aluOutSel=0001, rd=1.
- Shift masking: SRAI x2,x1,31 (0x41F0D113), rs1_data=0x80000000 -> opB=31, aluOutSel=1001. Also SLL with rs2_data=0x25 -> opB=5.
- Forwarding and x0 rule, two checks:
  - ADD x3,x1,x2 with wb_en=1, wb_rd=1, wb_data=0xAA, rs1_data=0x11 -> opA=0xAA.
  - Same instruction with wb_rd=0 and rs1 index 0 -> opA=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Then out_ready=1 -> the held op drains and the new op loads on the same edge.
- LUI, illegal and flush:
  - LUI x5,0x12345 -> opA=0x12345000, aluOutSel=1111.
  - opcode 0000011 -> illegal=1, rd=0.
  - flush with an accept in the same cycle -> out_valid=0 next cycle.
